// File: rtl/next_hop_select_if.sv
// -----------------------------------------------------------------------------
// next_hop_select_if
//   Bundles the control, table-read and result signals of next_hop_select.
//   slave  : the selector itself. It takes the start/count/bank data and
//            drives the read address and the results.
//   master : the surrounding logic that starts a scan, owns the neighbour
//            table banks and consumes the result.
//   Signals:
//     en            start pulse
//     neighborCount number of valid table entries
//     rd_index      read address to the ID/energy/Q banks
//     mSourceID     ID bank data (1-cycle registered read)
//     mEnergyLeft   energy bank data, Q2.14 unsigned
//     mQValue       Q-value bank data, Q2.14 unsigned
//     bestID        selected neighbour ID (0 = none)
//     bestQValue    Q-value of the selected neighbour
//     bestIndex     table index of the selected neighbour
//     found         an entry qualified in the last scan
//     busy          scan in progress
//     done          one-cycle completion pulse
// -----------------------------------------------------------------------------
interface next_hop_select_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  en;
  logic [WORD_WIDTH-1:0] neighborCount;
  logic [WORD_WIDTH-1:0] rd_index;
  logic [WORD_WIDTH-1:0] mSourceID;
  logic [WORD_WIDTH-1:0] mEnergyLeft;
  logic [WORD_WIDTH-1:0] mQValue;
  logic [WORD_WIDTH-1:0] bestID;
  logic [WORD_WIDTH-1:0] bestQValue;
  logic [WORD_WIDTH-1:0] bestIndex;
  logic                  found;
  logic                  busy;
  logic                  done;

  modport slave (
    input  en, neighborCount, mSourceID, mEnergyLeft, mQValue,
    output rd_index, bestID, bestQValue, bestIndex, found, busy, done
  );

  modport master (
    output en, neighborCount, mSourceID, mEnergyLeft, mQValue,
    input  rd_index, bestID, bestQValue, bestIndex, found, busy, done
  );
endinterface

// File: rtl/next_hop_select.sv
// -----------------------------------------------------------------------------
// next_hop_select
//   On a start pulse, scans the neighbour table banks written by the Q-table
//   update stage and returns the neighbour with the highest Q-value whose
//   remaining energy is at least E_MIN. The result is the next hop used when
//   this node forwards a data packet.
//   Ports:
//     clk   rising-edge clock
//     nrst  synchronous reset, active HIGH (1 = reset)
//     bus   next_hop_select_if.slave: start/count, table read port, results
//   Parameters:
//     WORD_WIDTH     width of IDs, energies, Q-values and counts
//     MAX_NEIGHBORS  table depth; the scan length is clamped to this
//     E_MIN          minimum energy (Q2.14) for an entry to be considered
// -----------------------------------------------------------------------------
module next_hop_select #(
  parameter int                  WORD_WIDTH    = 16,
  parameter int                  MAX_NEIGHBORS = 64,
  parameter logic [WORD_WIDTH-1:0] E_MIN       = 16'h0800
) (
  input  logic                clk,
  input  logic                nrst,
  next_hop_select_if.slave    bus
);

  localparam logic [WORD_WIDTH-1:0] MAX_N = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] ONE   = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] ZERO  = WORD_WIDTH'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                stateR;
  logic [WORD_WIDTH-1:0] scanLenR;   // latched, clamped entry count
  logic                  validR;     // bank outputs hold a requested entry
  logic [WORD_WIDTH-1:0] dataIdxR;   // index of the entry on the bank outputs

  logic [WORD_WIDTH-1:0] clampedN;
  logic [WORD_WIDTH-1:0] nextIdx;
  logic                  qualified;
  logic                  takeNew;

  // Scan length clamp, next read address and candidate selection.
  always_comb begin
    clampedN  = bus.neighborCount;
    nextIdx   = bus.rd_index + ONE;
    qualified = 1'b0;
    takeNew   = 1'b0;
    if (bus.neighborCount > MAX_N) begin
      clampedN = MAX_N;
    end else begin
      clampedN = bus.neighborCount;
    end
    // ID 0 marks an empty slot; low-energy neighbours are never chosen.
    qualified = (bus.mSourceID != ZERO) && (bus.mEnergyLeft >= E_MIN);
    // Strict greater-than keeps the earliest index on equal Q-values.
    if (qualified && (!bus.found || (bus.mQValue > bus.bestQValue))) begin
      takeNew = 1'b1;
    end else begin
      takeNew = 1'b0;
    end
  end

  // Scan FSM, read pipeline tag and registered results.
  always_ff @(posedge clk) begin
    if (nrst) begin
      stateR         <= IDLE;
      scanLenR       <= ZERO;
      validR         <= 1'b0;
      dataIdxR       <= ZERO;
      bus.rd_index   <= ZERO;
      bus.bestID     <= ZERO;
      bus.bestQValue <= ZERO;
      bus.bestIndex  <= ZERO;
      bus.found      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          bus.done <= 1'b0;
          validR   <= 1'b0;
          if (bus.en) begin
            scanLenR       <= clampedN;
            bus.bestID     <= ZERO;
            bus.bestQValue <= ZERO;
            bus.bestIndex  <= ZERO;
            bus.found      <= 1'b0;
            bus.rd_index   <= ZERO;
            bus.busy       <= 1'b1;
            stateR         <= (clampedN == ZERO) ? DRAIN : SCAN;
          end
        end
        SCAN: begin
          // The bank captures rd_index on this edge; its data is compared
          // on the next edge, tagged with this index.
          validR   <= 1'b1;
          dataIdxR <= bus.rd_index;
          if (nextIdx == scanLenR) begin
            stateR <= DRAIN;
          end else begin
            bus.rd_index <= nextIdx;
          end
        end
        DRAIN: begin
          validR <= 1'b0;
          stateR <= DONE;
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          stateR   <= IDLE;
        end
        default: begin
          validR <= 1'b0;
          stateR <= IDLE;
        end
      endcase

      // validR is only ever set while scanning, so this never collides
      // with the result clear done on an accepted start in IDLE.
      if (validR && takeNew) begin
        bus.bestID     <= bus.mSourceID;
        bus.bestQValue <= bus.mQValue;
        bus.bestIndex  <= dataIdxR;
        bus.found      <= 1'b1;
      end
    end
  end

endmodule
